// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the AES decryption datapath: walks the round-key index
// from NR down to 0 and presents the plaintext through a valid/ready handshake.
module aes_dec_round_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_ready,
  input  logic             abort,
  input  logic             out_ready,
  output logic             busy,
  output logic             load_state,
  output logic             state_en,
  output logic             sel_init,
  output logic             sel_last,
  output logic [IDX_W-1:0] round_idx,
  output logic             out_valid,
  output logic [2:0]       fsm_state
);

  // Handshake: the plaintext is transferred on a rising edge where
  // out_valid && out_ready; out_valid stays high until that edge.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_NR    = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NR - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t state;

  assign fsm_state = state;

  // Outputs are written for the state being entered, so every output is a
  // registered Moore decode of the state that is current on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      load_state <= 1'b0;
      state_en   <= 1'b0;
      sel_init   <= 1'b0;
      sel_last   <= 1'b0;
      out_valid  <= 1'b0;
      round_idx  <= '0;
    end else begin
      busy       <= 1'b1;
      load_state <= 1'b0;
      state_en   <= 1'b0;
      sel_init   <= 1'b0;
      sel_last   <= 1'b0;
      out_valid  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        round_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            // key_ready is only looked at here; a start without it is dropped.
            if (start && key_ready) begin
              state      <= LOAD;
              load_state <= 1'b1;
              round_idx  <= IDX_NR;
            end else begin
              busy      <= 1'b0;
              round_idx <= '0;
            end
          end
          LOAD: begin
            state     <= INIT;
            state_en  <= 1'b1;
            sel_init  <= 1'b1;
            round_idx <= IDX_NR;
          end
          INIT: begin
            state     <= ROUND;
            state_en  <= 1'b1;
            round_idx <= IDX_FIRST;
          end
          ROUND: begin
            // The <= guard keeps the index from ever wrapping below zero.
            if (round_idx <= IDX_ONE) begin
              state     <= FINAL;
              state_en  <= 1'b1;
              sel_last  <= 1'b1;
              round_idx <= '0;
            end else begin
              state_en  <= 1'b1;
              round_idx <= round_idx - IDX_ONE;
            end
          end
          FINAL: begin
            state     <= HOLD;
            out_valid <= 1'b1;
            round_idx <= '0;
          end
          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              busy      <= 1'b0;
              round_idx <= '0;
            end else begin
              out_valid <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            round_idx <= '0;
          end
        endcase
      end
    end
  end

  a_stage_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({load_state, sel_init, sel_last, out_valid}));

  a_idx_bound: assert property (@(posedge clk) disable iff (!rst)
    round_idx <= IDX_NR);

  a_busy_decode: assert property (@(posedge clk) disable iff (!rst)
    busy == (state != IDLE));

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl: NR=10 and NR=14 instances share the
// same inputs; each scenario task checks the per-cycle output timeline.
module tb_aes_dec_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic key_ready = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;

  logic       busy10, load10, en10, init10, last10, ov10;
  logic [3:0] idx10;
  logic [2:0] fsm10;
  logic       busy14, load14, en14, init14, last14, ov14;
  logic [3:0] idx14;
  logic [2:0] fsm14;

  logic [9:0] obs10, obs14;
  assign obs10 = {busy10, load10, en10, init10, last10, ov10, idx10};
  assign obs14 = {busy14, load14, en14, init14, last14, ov14, idx14};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_dec_round_ctrl #(.NR(10), .IDX_W(4)) dut10 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
    .abort(abort), .out_ready(out_ready), .busy(busy10),
    .load_state(load10), .state_en(en10), .sel_init(init10),
    .sel_last(last10), .round_idx(idx10), .out_valid(ov10),
    .fsm_state(fsm10)
  );

  aes_dec_round_ctrl #(.NR(14), .IDX_W(4)) dut14 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
    .abort(abort), .out_ready(out_ready), .busy(busy14),
    .load_state(load14), .state_en(en14), .sel_init(init14),
    .sel_last(last14), .round_idx(idx14), .out_valid(ov14),
    .fsm_state(fsm14)
  );

  // Expected {busy,load,en,init,last,valid,idx} for cycle c after start in c0,
  // assuming out_ready=1 in HOLD.
  function automatic logic [9:0] exp_vec(input int c, input int nr);
    logic [9:0] v;
    v = '0;
    if (c == 1)                     v = {6'b110000, 4'(nr)};
    else if (c == 2)                v = {6'b101100, 4'(nr)};
    else if (c >= 3 && c <= nr + 1) v = {6'b101000, 4'(nr + 2 - c)};
    else if (c == nr + 2)           v = {6'b101010, 4'd0};
    else if (c == nr + 3)           v = {6'b100001, 4'd0};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; key_ready = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick();
    tests++;
    if (obs10 !== 10'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", obs10, 10'd0);
    end
    tests++;
    if (fsm10 !== 3'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", fsm10);
    end
    rst = 1'b1;
    tick();
    key_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    tests++;
    if (idx10 !== 4'd5) begin
      fails++; $display("FAIL reset_mid_round_idx: got %0d want 5", idx10);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (obs10 !== 10'd0 || fsm10 !== 3'd0) begin
      fails++; $display("FAIL reset_mid_round: got %h/%0d want 000/0", obs10, fsm10);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    key_ready = 1'b1; out_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      tests++;
      if (obs10 !== exp_vec(c, 10)) begin
        fails++; $display("FAIL nominal_c%0d: got %h want %h", c, obs10, exp_vec(c, 10));
      end
    end
    tests++;
    if (fsm10 !== 3'd0) begin
      fails++; $display("FAIL nominal_idle: got %0d want 0", fsm10);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] e;
    int ov_cnt;
    ov_cnt = 0;
    key_ready = 1'b1; out_ready = 1'b0; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c >= 13 && c <= 18);
      out_ready = (c >= 18);
      if (c <= 13) e = exp_vec(c, 10);
      else if (c <= 18) e = {6'b100001, 4'd0};
      else e = '0;
      if (ov10) ov_cnt++;
      tests++;
      if (obs10 !== e) begin
        fails++; $display("FAIL backpressure_c%0d: got %h want %h", c, obs10, e);
      end
    end
    start = 1'b0;
    tests++;
    if (ov_cnt != 6) begin
      fails++; $display("FAIL backpressure_hold_len: got %0d want 6", ov_cnt);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_guard();
    int ov_cnt;
    ov_cnt = 0;
    key_ready = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (busy10 !== 1'b0) begin
        fails++; $display("FAIL guard_no_key_c%0d: busy got %b want 0", c, busy10);
      end
    end
    start = 1'b0;
    tick();
    key_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      // Restart attempt mid-ROUND plus key_ready dropping, neither may matter.
      start = (c >= 5 && c <= 6);
      key_ready = (c < 5);
      if (ov10) ov_cnt++;
      tests++;
      if (obs10 !== exp_vec(c, 10)) begin
        fails++; $display("FAIL guard_c%0d: got %h want %h", c, obs10, exp_vec(c, 10));
      end
    end
    tests++;
    if (ov_cnt != 1) begin
      fails++; $display("FAIL guard_one_valid: got %0d want 1", ov_cnt);
    end
    key_ready = 1'b1; start = 1'b0;
  endtask

  task automatic test_abort();
    key_ready = 1'b1; out_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
    end
    tests++;
    if (idx10 !== 4'd4) begin
      fails++; $display("FAIL abort_pre_idx: got %0d want 4", idx10);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (obs10 !== 10'd0 || fsm10 !== 3'd0) begin
      fails++; $display("FAIL abort_idle: got %h/%0d want 000/0", obs10, fsm10);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      tests++;
      if (obs10 !== 10'd0) begin
        fails++; $display("FAIL abort_quiet_%0d: got %h want 000", c, obs10);
      end
    end
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      tests++;
      if (obs10 !== exp_vec(c, 10)) begin
        fails++; $display("FAIL abort_rerun_c%0d: got %h want %h", c, obs10, exp_vec(c, 10));
      end
    end
  endtask

  task automatic test_nr14();
    int rounds;
    int first_ov;
    rounds = 0;
    first_ov = -1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    key_ready = 1'b1; out_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      start = 1'b0;
      if (en14 && !init14 && !last14) rounds++;
      if (ov14 && first_ov < 0) first_ov = c;
      tests++;
      if (obs14 !== exp_vec(c, 14)) begin
        fails++; $display("FAIL nr14_c%0d: got %h want %h", c, obs14, exp_vec(c, 14));
      end
    end
    tests++;
    if (rounds != 13) begin
      fails++; $display("FAIL nr14_round_len: got %0d want 13", rounds);
    end
    tests++;
    if (first_ov != 17) begin
      fails++; $display("FAIL nr14_latency: got %0d want 17", first_ov);
    end
    tests++;
    if (fsm14 !== 3'd0) begin
      fails++; $display("FAIL nr14_idle: got %0d want 0", fsm14);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_guard();
    test_abort();
    test_nr14();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
